// File: rtl/mtime_bus_port.sv
`default_nettype none
// ============================================================================
// Module   : mtime_bus_port
// Purpose  : Memory-mapped front end for the machine timer registers
//            (mtime / mtimecmp, low and high words). Accepts one data-memory
//            request at a time, performs the access on the CSR unit's timer
//            port (read-modify-write for sub-word writes) and returns a
//            response. Misaligned or unmapped accesses get an error response
//            without touching the timer port.
// Ports    : clk, rst (async, active-low)
//            req_*  : request handshake (valid/ready, addr, we, wdata, be)
//            rsp_*  : response handshake (valid/ready, data, err)
//            mtime* : CSR timer port (address, write data, write strobe,
//                     combinational read data)
// Revision : 1.0 - initial release
// ============================================================================
module mtime_bus_port #(
  // Default map follows the usual CLINT layout.
  parameter logic [31:0] MTIME_LO_ADDR    = 32'h0200_BFF8,
  parameter logic [31:0] MTIME_HI_ADDR    = 32'h0200_BFFC,
  parameter logic [31:0] MTIMECMP_LO_ADDR = 32'h0200_4000,
  parameter logic [31:0] MTIMECMP_HI_ADDR = 32'h0200_4004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [31:0] mtimeAddress_o,
  output logic [31:0] mtimeData_o,
  output logic        mtimeWe_o,
  input  logic [31:0] mtimeData_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q,    be_d;
  logic        we_q,    we_d;
  logic        err_q,   err_d;
  logic [31:0] data_q,  data_d;

  logic        w_hit;
  logic        w_req_err;
  logic [31:0] w_merged;

  // Address decode for the incoming request.
  assign w_hit = (req_addr_i == MTIME_LO_ADDR)    ||
                 (req_addr_i == MTIME_HI_ADDR)    ||
                 (req_addr_i == MTIMECMP_LO_ADDR) ||
                 (req_addr_i == MTIMECMP_HI_ADDR);

  assign w_req_err = (req_addr_i[1:0] != 2'b00) || !w_hit ||
                     (req_we_i && (req_be_i == 4'h0));

  // Byte merge of new write data over the value captured in READ. A full
  // write has every enable set, so it passes the request data unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign w_merged[gi*8 +: 8] = be_q[gi] ? wdata_q[gi*8 +: 8]
                                            : data_q[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          err_d   = w_req_err;
          if (w_req_err)                         state_d = RESP;
          else if (req_we_i && req_be_i == 4'hF) state_d = WRITE;
          else                                   state_d = READ;  // read or RMW
        end
      end
      READ: begin
        data_d  = mtimeData_i;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state so the timer port sees
  // stable address/data/strobe for the whole access cycle. Ready is gated
  // by rst so it stays low while reset is held.
  assign req_ready_o    = rst && (state_q == IDLE);
  assign mtimeAddress_o = (state_q == READ || state_q == WRITE) ? addr_q : '0;
  assign mtimeWe_o      = (state_q == WRITE);
  assign mtimeData_o    = (state_q == WRITE) ? w_merged : '0;
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_err_o      = (state_q == RESP) && err_q;
  assign rsp_data_o     = ((state_q == RESP) && !we_q && !err_q) ? data_q : '0;

endmodule
`default_nettype wire

// File: doc/mtime_bus_port.md
Name: mtime_bus_port

Overview:
- Memory-mapped front end for the machine timer registers (mtime, mtimecmp, each split into low and high words).
- Responder on the core's data-memory request/response handshake.
- Initiator on the CSR unit's timer port. It drives the address, write data and write enable, and samples the combinational read data the CSR unit returns.
- Serialises one access at a time. Sub-word writes are handled by read-modify-write. Unmapped or misaligned accesses are answered with an error response.

Parameters:
- MTIME_LO_ADDR, default MTIME_MEM_ADDRESS_LOW: byte address of mtime[31:0].
- MTIME_HI_ADDR, default MTIME_MEM_ADDRESS_HIGH: byte address of mtime[63:32].
- MTIMECMP_LO_ADDR, default MTIMECMP_MEM_ADDRESS_LOW: byte address of mtimecmp[31:0].
- MTIMECMP_HI_ADDR, default MTIMECMP_MEM_ADDRESS_HIGH: byte address of mtimecmp[63:32].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of clk.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o at a rising edge.
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  32  write data.
- req_be_i  in  4  byte enables; ignored for reads.
- rsp_valid_o  out  1  response valid; held until rsp_ready_i.
- rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i at a rising edge.
- rsp_data_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = unmapped or misaligned access.
- mtimeAddress_o  out  32  address to the CSR timer port.
- mtimeData_o  out  32  write data to the CSR timer port.
- mtimeWe_o  out  1  write strobe to the CSR timer port; exactly one cycle per write.
- mtimeData_i  in  32  combinational read data from the CSR timer port.

Behaviour:
- Reset (rst low) forces:
  - state = IDLE;
  - req_ready_o = 0 while rst is low, then 1 in IDLE;
  - rsp_valid_o, rsp_err_o and mtimeWe_o = 0;
  - rsp_data_o, mtimeAddress_o, mtimeData_o and all latched request fields = 0.
- Reset asserted mid-operation abandons the access. Any mtimeWe_o pulse in flight is dropped that same instant, and no response is issued.
- States are IDLE, READ, WRITE and RESP. All outputs are registered or decoded from the state.
- IDLE:
  - req_ready_o = 1; mtimeAddress_o = 0; mtimeWe_o = 0.
  - On acceptance, latch addr, we, wdata and be.
  - Error condition: addr[1:0] != 0, or addr matches none of the four parameters, or it is a write with be == 0. Go to RESP with rsp_err_o = 1. No timer-port access occurs.
  - Read: go to READ.
  - Write with be == 4'hF: go to WRITE.
  - Write with any other non-zero be: go to READ (the read-modify-write path).
- READ (1 cycle):
  - mtimeAddress_o = latched addr; mtimeWe_o = 0.
  - Capture mtimeData_i into the data register at the end of the cycle.
  - For a read, go to RESP. For a RMW, go to WRITE.
- WRITE (1 cycle):
  - mtimeAddress_o = latched addr; mtimeWe_o = 1.
  - mtimeData_o = merged data. For each byte i, take req_wdata byte i if be[i], otherwise captured byte i. A full write uses req_wdata directly.
  - Go to RESP.
- RESP:
  - rsp_valid_o = 1. rsp_data_o = captured data for reads, 0 otherwise. rsp_err_o as decided in IDLE.
  - req_ready_o = 0 and mtimeAddress_o = 0.
  - Stay in RESP while rsp_ready_i is low. Go to IDLE on rsp_ready_i.
  - Earliest next acceptance is the cycle after the handshake; there is no back-to-back overlap.
- Latency, counted from the acceptance edge to rsp_valid_o high:
  - error: 1 cycle;
  - full write: 2 cycles;
  - read: 2 cycles;
  - RMW: 3 cycles.
- Timing rules:
  - A read returns the mtime value as seen during the READ cycle.
  - A RMW on mtime writes back the value captured in READ, merged with the new bytes. Any increment of mtime between READ and WRITE is overwritten; this is accepted behaviour.
  - Address, data and strobe to the CSR unit are stable for the whole access cycle, with no glitching between states.
- Unmapped-address errors perform no CSR access, so mtip is untouched. Writes to either mtimecmp word clear mtip inside the CSR unit; this block performs no extra action.

Test Plan:
1. Release reset, then issue a full write of 0x0000_0100 (be=F) to MTIMECMP_LO_ADDR. Required: mtimeWe_o high for exactly 1 cycle, 1 cycle after acceptance, with mtimeData_o = 0x0000_0100. rsp_valid_o follows 2 cycles after acceptance with rsp_err_o = 0 and rsp_data_o = 0. A subsequent read of the same address returns 0x0000_0100.
2. With mtimecmp_hi preset to 0x1122_3344, write 0x0000_AB00 with be=4'b0010 to MTIMECMP_HI_ADDR. Required: READ then WRITE, with mtimeData_o = 0x1122_AB44 and rsp_valid_o 3 cycles after acceptance.
3. Read MTIME_LO_ADDR twice, with 10 idle cycles between. Required: the second value minus the first = 10 plus the per-access latency offset; rsp_err_o = 0 on both.
4. Read address MTIME_LO_ADDR+2, then an unmapped address 0x0000_0000. Required: rsp_err_o = 1 and rsp_data_o = 0 for both, 1 cycle latency, and mtimeAddress_o stays 0 with mtimeWe_o never asserted.
5. Hold rsp_ready_i low for 4 cycles on a read response. Required: rsp_valid_o and rsp_data_o stay stable and req_ready_o stays 0. After the handshake, req_ready_o = 1 on the next cycle.
6. Drop rst asynchronously during a WRITE cycle. Required: mtimeWe_o and rsp_valid_o fall immediately with no clk edge. After rst rises, the block is in IDLE with req_ready_o = 1 and no pending response.
